spi_slave_sync: RTL and testbench

//  Parametrised SPI slave; all logic on the system clock clk, no logic clocked by sclk.

---
 rtl/spi_slave_sync.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_sync.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on clk: sclk/mosi/ce0 are synchronised and edge-detected.
// Optional underrun output enabled by defining SPI_SLAVE_UNDERRUN_EN.
module spi_slave_sync #(
   parameter int unsigned WIDTH       = 8,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             ce0,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             busy,
   output logic             overrun
`ifdef SPI_SLAVE_UNDERRUN_EN
   ,
   output logic             underrun
`endif
);

   localparam int unsigned CW          = $clog2(WIDTH + 1);
   localparam bit          SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ce0_sync;
   logic                   sclk_d, ce0_d;
   logic                   sclk_s, mosi_s, ce0_s;
   logic                   sample_edge, shift_edge, ce0_fall, ce0_rise;

   logic [CW-1:0]          count, count_nxt;
   logic                   skip, skip_nxt;
   logic [WIDTH-1:0]       rx_shift, rx_shift_nxt, tx_shift, tx_shift_nxt;
   logic [WIDTH-1:0]       hold, hold_nxt, rx_data_nxt;
   logic                   tx_ready_nxt, rx_valid_nxt, overrun_nxt, underrun_nxt;
   logic                   miso_nxt, active_nxt, load, word_done;

   // Input synchronisers plus one edge-detect flop each for sclk and ce0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= {SYNC_STAGES{CPOL}};
         mosi_sync <= '0;
         ce0_sync  <= '1;
         sclk_d    <= CPOL;
         ce0_d     <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ce0_sync  <= {ce0_sync[SYNC_STAGES-2:0], ce0};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         ce0_d     <= ce0_sync[SYNC_STAGES-1];
      end
   end

   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign ce0_s       = ce0_sync[SYNC_STAGES-1];
   assign sample_edge = SAMPLE_RISE ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
   assign shift_edge  = SAMPLE_RISE ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
   assign ce0_fall    = ~ce0_s & ce0_d;
   assign ce0_rise    = ce0_s & ~ce0_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         skip     <= 1'b0;
         rx_shift <= '0;
         tx_shift <= '0;
         hold     <= '0;
         tx_ready <= 1'b1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
         miso     <= 1'b0;
         miso_oe  <= 1'b0;
         busy     <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
         underrun <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         skip     <= skip_nxt;
         rx_shift <= rx_shift_nxt;
         tx_shift <= tx_shift_nxt;
         hold     <= hold_nxt;
         tx_ready <= tx_ready_nxt;
         rx_data  <= rx_data_nxt;
         rx_valid <= rx_valid_nxt;
         overrun  <= overrun_nxt;
         miso     <= miso_nxt;
         miso_oe  <= active_nxt;
         busy     <= active_nxt;
`ifdef SPI_SLAVE_UNDERRUN_EN
         underrun <= underrun_nxt;
`endif
      end
   end

   // A finished word is delivered even if ce0 rises in the same cycle
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      skip_nxt     = skip;
      rx_shift_nxt = rx_shift;
      tx_shift_nxt = tx_shift;
      hold_nxt     = hold;
      tx_ready_nxt = tx_ready;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = rx_valid;
      overrun_nxt  = 1'b0;
      load         = 1'b0;
      word_done    = 1'b0;

      case (state)
         IDLE: begin
            if (ce0_fall) begin
               state_nxt = ACTIVE;
               load      = 1'b1;
               count_nxt = '0;
               skip_nxt  = CPHA;
            end
         end
         ACTIVE: begin
            word_done = (count == CW'(WIDTH));
            if (ce0_rise) begin
               state_nxt = IDLE;
               count_nxt = '0;
               skip_nxt  = 1'b0;
            end else if (word_done) begin
               load      = 1'b1;
               count_nxt = '0;
               skip_nxt  = 1'b1;
            end else if (sample_edge) begin
               rx_shift_nxt = {rx_shift[WIDTH-2:0], mosi_s};
               count_nxt    = count + CW'(1);
            end else if (shift_edge) begin
               if (skip) skip_nxt = 1'b0;
               else      tx_shift_nxt = {tx_shift[WIDTH-2:0], 1'b0};
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Load sees the old holding content; a same-cycle write refills it
      if (load) tx_shift_nxt = tx_ready ? '0 : hold;
      underrun_nxt = load & tx_ready;
      if (tx_valid && tx_ready) begin
         hold_nxt     = tx_data;
         tx_ready_nxt = 1'b0;
      end else if (load) begin
         tx_ready_nxt = 1'b1;
      end

      if (word_done) begin
         rx_data_nxt  = rx_shift;
         rx_valid_nxt = 1'b1;
         overrun_nxt  = rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
         rx_valid_nxt = 1'b0;
      end

      active_nxt = (state_nxt == ACTIVE);
      miso_nxt   = active_nxt & tx_shift_nxt[WIDTH-1];
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: one instance per CPOL/CPHA mode (index = CPOL*2+CPHA),
// each with its own sclk/ce0 so frames run on one mode at a time.
module tb_spi_slave_sync;

   localparam time HALF = 80ns;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mosi = 1'b0;
   logic [3:0] sclk = 4'b1100;
   logic [3:0] ce0 = 4'b1111;
   logic [3:0] tx_valid = 4'b0000;
   logic [3:0] rx_ready = 4'b0000;
   logic [7:0] tx_data = 8'h00;
   logic [3:0] miso, miso_oe, tx_ready, rx_valid, busy, overrun, underrun;
   logic [7:0] rx_data [4];

   int n_assert = 0;
   int n_fail   = 0;
   int ovr_cnt [4];
   int unr_cnt [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_sync #(
         .WIDTH(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .SYNC_STAGES(2)
      ) u_dut (
         .clk(clk), .rst(rst), .sclk(sclk[g]), .mosi(mosi), .ce0(ce0[g]),
         .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data), .tx_valid(tx_valid[g]),
         .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
         .rx_ready(rx_ready[g]), .busy(busy[g]), .overrun(overrun[g])
`ifdef SPI_SLAVE_UNDERRUN_EN
         , .underrun(underrun[g])
`endif
      );
   end

`ifndef SPI_SLAVE_UNDERRUN_EN
   assign underrun = 4'b0000;
`endif

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (overrun[k] === 1'b1)  ovr_cnt[k] <= ovr_cnt[k] + 1;
         if (underrun[k] === 1'b1) unr_cnt[k] <= unr_cnt[k] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tx_write(input int m, input logic [7:0] d);
      int n;
      @(negedge clk);
      tx_data     = d;
      tx_valid[m] = 1'b1;
      n = 0;
      while (tx_ready[m] !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("tx_write_accept", 32'(tx_ready[m]), 32'd1);
      @(negedge clk);
      tx_valid[m] = 1'b0;
   endtask

   task automatic rx_take(input int m);
      @(negedge clk);
      rx_ready[m] = 1'b1;
      @(negedge clk);
      rx_ready[m] = 1'b0;
      check("rx_valid_cleared", 32'(rx_valid[m]), 32'd0);
   endtask

   task automatic frame_start(input int m);
      @(negedge clk);
      ce0[m] = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic frame_end(input int m);
      repeat (8) @(negedge clk);
      ce0[m] = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Master side of one word (first nbits bits, MSB first); returns the bits read from miso
   task automatic xfer(input int m, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      logic [1:0] md;
      md = 2'(m);
      mi = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (md[0] == 1'b0) begin
            mosi = mo[i];
            #HALF; mi[i] = miso[m]; sclk[m] = ~md[1];
            #HALF; sclk[m] = md[1];
         end else begin
            #HALF; sclk[m] = ~md[1]; mosi = mo[i];
            #HALF; mi[i] = miso[m]; sclk[m] = md[1];
         end
      end
   endtask

   initial begin
      logic [7:0] mi;
      int ovr0, unr0;

      // reset state
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      for (int m = 0; m < 4; m++) begin
         check("rst_miso", 32'(miso[m]), 32'd0);
         check("rst_miso_oe", 32'(miso_oe[m]), 32'd0);
         check("rst_tx_ready", 32'(tx_ready[m]), 32'd1);
         check("rst_rx_data", 32'(rx_data[m]), 32'd0);
         check("rst_rx_valid", 32'(rx_valid[m]), 32'd0);
         check("rst_busy", 32'(busy[m]), 32'd0);
         check("rst_overrun", 32'(overrun[m]), 32'd0);
      end

      // mode 0: slave sends 0xA5, master sends 0x3C
      tx_write(0, 8'hA5);
      check("m0_tx_ready_full", 32'(tx_ready[0]), 32'd0);
      frame_start(0);
      check("m0_busy", 32'(busy[0]), 32'd1);
      check("m0_miso_oe", 32'(miso_oe[0]), 32'd1);
      check("m0_tx_ready_freed", 32'(tx_ready[0]), 32'd1);
      xfer(0, 8'h3C, 8, mi);
      check("m0_miso_word", 32'(mi), 32'hA5);
      check("m0_rx_valid", 32'(rx_valid[0]), 32'd1);
      check("m0_rx_data", 32'(rx_data[0]), 32'h3C);
      rx_take(0);
      frame_end(0);
      check("m0_busy_end", 32'(busy[0]), 32'd0);
      check("m0_miso_oe_end", 32'(miso_oe[0]), 32'd0);
      check("m0_miso_end", 32'(miso[0]), 32'd0);

      // all four modes: preload 0x5A, master sends 0x81
      for (int m = 0; m < 4; m++) begin
         tx_write(m, 8'h5A);
         frame_start(m);
         xfer(m, 8'h81, 8, mi);
         frame_end(m);
         check("mode_miso_word", 32'(mi), 32'h5A);
         check("mode_rx_data", 32'(rx_data[m]), 32'h81);
         check("mode_rx_valid", 32'(rx_valid[m]), 32'd1);
         rx_take(m);
      end

      // two-word frame, second tx word written after the first load
      for (int m = 0; m < 4; m++) begin
         ovr0 = ovr_cnt[m];
         rx_ready[m] = 1'b1;
         tx_write(m, 8'h11);
         frame_start(m);
         check("w2_tx_ready_after_load", 32'(tx_ready[m]), 32'd1);
         tx_write(m, 8'h22);
         xfer(m, 8'hC3, 8, mi);
         check("w2_first", 32'(mi), 32'h11);
         xfer(m, 8'h3C, 8, mi);
         check("w2_second", 32'(mi), 32'h22);
         frame_end(m);
         rx_ready[m] = 1'b0;
         check("w2_rx_data", 32'(rx_data[m]), 32'h3C);
         check("w2_no_overrun", 32'(ovr_cnt[m] - ovr0), 32'd0);
      end

      // overrun: two words with rx_ready held low
      ovr0 = ovr_cnt[0];
      frame_start(0);
      xfer(0, 8'h01, 8, mi);
      xfer(0, 8'h02, 8, mi);
      frame_end(0);
      check("ovr_rx_data", 32'(rx_data[0]), 32'h02);
      check("ovr_rx_valid", 32'(rx_valid[0]), 32'd1);
      check("ovr_pulses", 32'(ovr_cnt[0] - ovr0), 32'd1);
      rx_take(0);

      // sclk toggling while deselected has no effect
      for (int i = 0; i < 8; i++) begin
         #HALF; sclk[0] = 1'b1;
         #HALF; sclk[0] = 1'b0;
      end
      repeat (8) @(negedge clk);
      check("idle_sclk_rx_valid", 32'(rx_valid[0]), 32'd0);
      check("idle_sclk_busy", 32'(busy[0]), 32'd0);

      // aborted frame after 5 bits, then a clean 0xF0 frame
      frame_start(0);
      xfer(0, 8'hAB, 5, mi);
      frame_end(0);
      check("abort_rx_valid", 32'(rx_valid[0]), 32'd0);
      check("abort_busy", 32'(busy[0]), 32'd0);
      frame_start(0);
      xfer(0, 8'hF0, 8, mi);
      frame_end(0);
      check("after_abort_rx_data", 32'(rx_data[0]), 32'hF0);
      check("after_abort_rx_valid", 32'(rx_valid[0]), 32'd1);
      rx_take(0);

      // empty holding register at ce0 fall sends zeros
      check("empty_tx_ready", 32'(tx_ready[0]), 32'd1);
      unr0 = unr_cnt[0];
      frame_start(0);
`ifdef SPI_SLAVE_UNDERRUN_EN
      check("underrun_pulse", 32'(unr_cnt[0] - unr0), 32'd1);
`endif
      xfer(0, 8'h55, 8, mi);
      frame_end(0);
      check("empty_miso_word", 32'(mi), 32'h00);
      check("empty_rx_data", 32'(rx_data[0]), 32'h55);
      rx_take(0);

      // reset in the middle of a frame
      tx_write(0, 8'h77);
      frame_start(0);
      tx_write(0, 8'h99);
      check("midrst_holding_full", 32'(tx_ready[0]), 32'd0);
      xfer(0, 8'hFF, 3, mi);
      rst    = 1'b1;
      ce0[0] = 1'b1;
      #1;
      check("midrst_busy", 32'(busy[0]), 32'd0);
      check("midrst_miso_oe", 32'(miso_oe[0]), 32'd0);
      check("midrst_tx_ready", 32'(tx_ready[0]), 32'd1);
      check("midrst_rx_valid", 32'(rx_valid[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("postrst_busy", 32'(busy[0]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
